// File: rtl/conv_pass_sched.sv
// -----------------------------------------------------------------------------
// conv_pass_sched
//
// Pass scheduler for one convolution layer. The layer's output channels are
// split into NUM_PASSES = ceil(CONV_OUT_CH / OC_PER_PASS) passes. For every
// pass the block runs this sequence:
//   1. requests a weight-buffer load,
//   2. pulses a clear to the conv iterator,
//   3. enables the conv controller until it reports finish,
//   4. waits PIPE_LAT cycles for the accumulator pipeline to drain,
//   5. requests an output store.
// After the last store the block pulses done and returns to idle.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   layer start, only looked at while idle
//   abort     in   synchronous abort, returns to idle from any state
//   ld_ack    in   weight load for the current pass is complete
//   finish    in   conv controller finished the current pass
//   st_ack    in   output store for the current pass is complete
//   ld_req    out  weight load request (level, held until ld_ack)
//   st_req    out  output store request (level, held until st_ack)
//   conv_clr  out  one-cycle clear pulse to the conv iterator before each pass
//   en_ctrl   out  conv controller enable (level)
//   pass_idx  out  current pass index, 0..NUM_PASSES-1
//   busy      out  high in every state except idle
//   done      out  one-cycle pulse when the layer is complete
//
// Every output is a registered Moore output. Each one is decoded from the
// next state and stored in a flop, so it changes exactly on the clock edge
// where the state changes.
// -----------------------------------------------------------------------------
module conv_pass_sched #(
    parameter int CONV_OUT_CH = 32,
    parameter int OC_PER_PASS = 8,
    parameter int PIPE_LAT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       ld_ack,
    input  logic       finish,
    input  logic       st_ack,
    output logic       ld_req,
    output logic       st_req,
    output logic       conv_clr,
    output logic       en_ctrl,
    output logic [7:0] pass_idx,
    output logic       busy,
    output logic       done
);

    localparam int         NUM_PASSES = (CONV_OUT_CH + OC_PER_PASS - 1) / OC_PER_PASS;
    localparam logic [7:0] LAST_PASS  = 8'(NUM_PASSES - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT);

    // Reject parameter sets the 8-bit pass index or 4-bit drain counter
    // cannot represent. This check runs at elaboration only.
    if (NUM_PASSES < 1 || NUM_PASSES > 255) begin : g_bad_num_passes
        $error("conv_pass_sched: NUM_PASSES must be in 1..255");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_pipe_lat
        $error("conv_pass_sched: PIPE_LAT must be in 0..15");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] pass_idx_q,  pass_idx_d;

    logic ld_req_q,   ld_req_d;
    logic st_req_q,   st_req_d;
    logic conv_clr_q, conv_clr_d;
    logic en_ctrl_q,  en_ctrl_d;
    logic busy_q,     busy_d;
    logic done_q,     done_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pass_idx_d  = pass_idx_q;

        if (abort) begin
            // Abort wins over every other transition, including start.
            state_d     = S_IDLE;
            pass_idx_d  = 8'd0;
            drain_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_LOAD;
                        pass_idx_d = 8'd0;
                    end
                end
                S_LOAD: begin
                    if (ld_ack) begin
                        state_d = S_CLR;
                    end
                end
                S_CLR: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (finish) begin
                        // With no pipeline latency there is nothing to drain.
                        if (PIPE_LAT == 0) begin
                            state_d = S_STORE;
                        end else begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = DRAIN_INIT;
                        end
                    end
                end
                S_DRAIN: begin
                    // Leaving at a count of 1 keeps the drain to exactly PIPE_LAT
                    // cycles. The <= also catches a count of 0, so the FSM can
                    // never get stuck here.
                    if (drain_cnt_q <= 4'd1) begin
                        state_d     = S_STORE;
                        drain_cnt_d = 4'd0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end
                end
                S_STORE: begin
                    if (st_ack) begin
                        // The index stops at LAST_PASS and never wraps.
                        if (pass_idx_q >= LAST_PASS) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_LOAD;
                            pass_idx_d = pass_idx_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d    = S_IDLE;
                    pass_idx_d = 8'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from the next state so they can be registered
    // -------------------------------------------------------------------------
    always_comb begin
        ld_req_d   = (state_d == S_LOAD);
        st_req_d   = (state_d == S_STORE);
        conv_clr_d = (state_d == S_CLR);
        en_ctrl_d  = (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 4'd0;
            pass_idx_q  <= 8'd0;
            ld_req_q    <= 1'b0;
            st_req_q    <= 1'b0;
            conv_clr_q  <= 1'b0;
            en_ctrl_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            pass_idx_q  <= pass_idx_d;
            ld_req_q    <= ld_req_d;
            st_req_q    <= st_req_d;
            conv_clr_q  <= conv_clr_d;
            en_ctrl_q   <= en_ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ld_req   = ld_req_q;
    assign st_req   = st_req_q;
    assign conv_clr = conv_clr_q;
    assign en_ctrl  = en_ctrl_q;
    assign pass_idx = pass_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_conv_pass_sched.sv
// -----------------------------------------------------------------------------
// tb_conv_pass_sched
//
// Testbench for conv_pass_sched. It builds three instances:
//   a: default parameters (4 passes, PIPE_LAT = 3), driven step by step
//   b: 8/8, PIPE_LAT = 0, acks and finish tied high (zero-wait timing)
//   c: 10/4, PIPE_LAT = 3, acks and finish tied high (pass-count rounding)
//
// Expected pass indices and start-to-st_req latencies are pushed to queues
// when stimulus is driven. They are popped and compared when the design
// produces the matching output.
// -----------------------------------------------------------------------------
module tb_conv_pass_sched;

    localparam int NP_A = 4;
    localparam int PL_A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_start, a_abort, a_ld_ack, a_finish, a_st_ack;
    logic       a_ld_req, a_st_req, a_conv_clr, a_en_ctrl, a_busy, a_done;
    logic [7:0] a_pass_idx;

    logic       b_start, b_abort, b_ld_ack, b_finish, b_st_ack;
    logic       b_ld_req, b_st_req, b_conv_clr, b_en_ctrl, b_busy, b_done;
    logic [7:0] b_pass_idx;

    logic       c_start, c_abort, c_ld_ack, c_finish, c_st_ack;
    logic       c_ld_req, c_st_req, c_conv_clr, c_en_ctrl, c_busy, c_done;
    logic [7:0] c_pass_idx;

    conv_pass_sched #(.CONV_OUT_CH(32), .OC_PER_PASS(8), .PIPE_LAT(PL_A)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .ld_ack(a_ld_ack), .finish(a_finish), .st_ack(a_st_ack),
        .ld_req(a_ld_req), .st_req(a_st_req), .conv_clr(a_conv_clr),
        .en_ctrl(a_en_ctrl), .pass_idx(a_pass_idx), .busy(a_busy), .done(a_done)
    );

    conv_pass_sched #(.CONV_OUT_CH(8), .OC_PER_PASS(8), .PIPE_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .ld_ack(b_ld_ack), .finish(b_finish), .st_ack(b_st_ack),
        .ld_req(b_ld_req), .st_req(b_st_req), .conv_clr(b_conv_clr),
        .en_ctrl(b_en_ctrl), .pass_idx(b_pass_idx), .busy(b_busy), .done(b_done)
    );

    conv_pass_sched #(.CONV_OUT_CH(10), .OC_PER_PASS(4), .PIPE_LAT(3)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .abort(c_abort),
        .ld_ack(c_ld_ack), .finish(c_finish), .st_ack(c_st_ack),
        .ld_req(c_ld_req), .st_req(c_st_req), .conv_clr(c_conv_clr),
        .en_ctrl(c_en_ctrl), .pass_idx(c_pass_idx), .busy(c_busy), .done(c_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pass_q[$];
    int lat_q[$];

    // Pulse counters for instance a, sampled away from the active edge.
    int a_clr_cnt  = 0;
    int a_done_cnt = 0;
    always @(negedge clk) begin
        if (a_conv_clr) a_clr_cnt++;
        if (a_done)     a_done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b0;
        #22;
        n_checks++;
        if ({a_ld_req, a_st_req, a_conv_clr, a_en_ctrl, a_busy, a_done, a_pass_idx} !== 14'd0)
            $display("FAIL reset_init: outputs=%b required all zero",
                     {a_ld_req, a_st_req, a_conv_clr, a_en_ctrl, a_busy, a_done, a_pass_idx});
        else n_pass++;
        @(negedge clk) reset = 1'b1;

        // Bring instance a into RUN, then reset it asynchronously.
        a_start = 1'b1; tick; a_start = 1'b0;
        a_ld_ack = 1'b1; tick; a_ld_ack = 1'b0;
        tick;
        n_checks++;
        if (a_en_ctrl !== 1'b1) $display("FAIL reset_run_entry: en_ctrl=%b required 1", a_en_ctrl);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({a_ld_req, a_st_req, a_conv_clr, a_en_ctrl, a_busy, a_done, a_pass_idx} !== 14'd0)
            $display("FAIL reset_midrun: outputs=%b required all zero",
                     {a_ld_req, a_st_req, a_conv_clr, a_en_ctrl, a_busy, a_done, a_pass_idx});
        else n_pass++;
        @(negedge clk) reset = 1'b1;

        a_start = 1'b1; tick; a_start = 1'b0;
        n_checks++;
        if ({a_busy, a_ld_req, a_pass_idx} !== {1'b1, 1'b1, 8'd0})
            $display("FAIL reset_restart: busy=%b ld_req=%b pass_idx=%0d required 1 1 0",
                     a_busy, a_ld_req, a_pass_idx);
        else n_pass++;
        a_abort = 1'b1; tick; a_abort = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Runs one full layer on instance a.
    //   ack_wait: cycles a request is held before its ack
    //   run_wait: RUN cycles before finish
    //   stray:    stray acks and a start pulse in the first RUN cycle
    //   hold_fin: finish held high for the whole layer
    task automatic run_layer_a(input int ack_wait, input int run_wait,
                               input bit stray, input bit hold_fin, input string tag);
        int clr0, done0, lat, exp;
        clr0  = a_clr_cnt;
        done0 = a_done_cnt;
        a_finish = hold_fin;
        for (int p = 0; p < NP_A; p++) pass_q.push_back(p);
        a_start = 1'b1; tick; a_start = 1'b0;
        n_checks++;
        if ({a_busy, a_ld_req} !== 2'b11)
            $display("FAIL %s_start: busy=%b ld_req=%b required 1 1", tag, a_busy, a_ld_req);
        else n_pass++;

        for (int p = 0; p < NP_A; p++) begin
            repeat (ack_wait) tick;
            a_ld_ack = 1'b1; tick; a_ld_ack = 1'b0;
            n_checks++;
            if ({a_conv_clr, a_ld_req, a_en_ctrl} !== 3'b100)
                $display("FAIL %s_clr p%0d: clr/ld_req/en=%b required 100", tag, p,
                         {a_conv_clr, a_ld_req, a_en_ctrl});
            else n_pass++;
            tick;
            n_checks++;
            if ({a_conv_clr, a_en_ctrl} !== 2'b01)
                $display("FAIL %s_run p%0d: clr/en=%b required 01", tag, p, {a_conv_clr, a_en_ctrl});
            else n_pass++;
            for (int i = 0; i < run_wait; i++) begin
                if (stray && i == 0) begin
                    a_ld_ack = 1'b1;
                    a_st_ack = 1'b1;
                    if (p >= 1) a_start = 1'b1;
                end
                tick;
                a_ld_ack = 1'b0; a_st_ack = 1'b0; a_start = 1'b0;
                n_checks++;
                if ({a_en_ctrl, a_ld_req, a_st_req} !== 3'b100 || a_pass_idx !== 8'(p))
                    $display("FAIL %s_run_hold p%0d: en/ld/st=%b pass_idx=%0d required 100 %0d",
                             tag, p, {a_en_ctrl, a_ld_req, a_st_req}, a_pass_idx, p);
                else n_pass++;
            end
            a_finish = 1'b1;
            lat_q.push_back(1 + PL_A);
            tick;
            if (!hold_fin) a_finish = 1'b0;
            n_checks++;
            if (a_en_ctrl !== 1'b0) $display("FAIL %s_en_drop p%0d: en_ctrl=%b required 0", tag, p, a_en_ctrl);
            else n_pass++;
            lat = 1;
            while (!a_st_req && lat < 20) begin tick; lat++; end
            exp = lat_q.pop_front();
            n_checks++;
            if (lat !== exp) $display("FAIL %s_st_latency p%0d: cycles=%0d required %0d", tag, p, lat, exp);
            else n_pass++;
            exp = pass_q.pop_front();
            n_checks++;
            if (a_pass_idx !== 8'(exp))
                $display("FAIL %s_pass_idx p%0d: pass_idx=%0d required %0d", tag, p, a_pass_idx, exp);
            else n_pass++;
            repeat (ack_wait) tick;
            a_st_ack = 1'b1; tick; a_st_ack = 1'b0;
            n_checks++;
            if (a_st_req !== 1'b0) $display("FAIL %s_st_drop p%0d: st_req=%b required 0", tag, p, a_st_req);
            else n_pass++;
            if (p == NP_A - 1) begin
                n_checks++;
                if ({a_done, a_busy} !== 2'b11)
                    $display("FAIL %s_done: done/busy=%b required 11", tag, {a_done, a_busy});
                else n_pass++;
                tick;
                n_checks++;
                if ({a_done, a_busy, a_pass_idx} !== {2'b00, 8'(NP_A - 1)})
                    $display("FAIL %s_idle: done/busy=%b pass_idx=%0d required 00 %0d", tag,
                             {a_done, a_busy}, a_pass_idx, NP_A - 1);
                else n_pass++;
            end else begin
                n_checks++;
                if (a_ld_req !== 1'b1) $display("FAIL %s_next_load p%0d: ld_req=%b required 1", tag, p, a_ld_req);
                else n_pass++;
            end
        end
        a_finish = 1'b0;
        n_checks++;
        if (a_clr_cnt - clr0 !== NP_A)
            $display("FAIL %s_clr_count: pulses=%0d required %0d", tag, a_clr_cnt - clr0, NP_A);
        else n_pass++;
        n_checks++;
        if (a_done_cnt - done0 !== 1)
            $display("FAIL %s_done_count: pulses=%0d required 1", tag, a_done_cnt - done0);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_abort;
        int guard, done0;
        done0 = a_done_cnt;
        guard = 0;
        a_ld_ack = 1'b1;
        a_finish = 1'b1;
        a_start = 1'b1; tick; a_start = 1'b0;
        while (guard < 200) begin
            if (a_st_req) begin
                if (a_pass_idx == 8'd2) break;
                a_st_ack = 1'b1; tick; a_st_ack = 1'b0;
            end else begin
                tick;
            end
            guard++;
        end
        n_checks++;
        if (guard >= 200) $display("FAIL abort_reach_store: cycles=%0d required <200", guard);
        else n_pass++;
        a_abort = 1'b1; tick; a_abort = 1'b0;
        a_ld_ack = 1'b0;
        a_finish = 1'b0;
        n_checks++;
        if ({a_st_req, a_busy, a_pass_idx} !== 10'd0)
            $display("FAIL abort_store: st_req=%b busy=%b pass_idx=%0d required 0 0 0",
                     a_st_req, a_busy, a_pass_idx);
        else n_pass++;
        repeat (3) tick;
        n_checks++;
        if (a_done_cnt !== done0) $display("FAIL abort_no_done: pulses=%0d required %0d", a_done_cnt, done0);
        else n_pass++;

        a_start = 1'b1; a_abort = 1'b1; tick; a_start = 1'b0; a_abort = 1'b0;
        n_checks++;
        if ({a_busy, a_ld_req, a_pass_idx} !== 10'd0)
            $display("FAIL abort_start_same: busy=%b ld_req=%b pass_idx=%0d required 0 0 0",
                     a_busy, a_ld_req, a_pass_idx);
        else n_pass++;
        tick;
        n_checks++;
        if (a_busy !== 1'b0) $display("FAIL abort_stay_idle: busy=%b required 0", a_busy);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_zero_wait;
        int k;
        b_start = 1'b1; tick; b_start = 1'b0;
        k = 1;
        while (!b_done && k < 20) begin tick; k++; end
        n_checks++;
        if (k !== 5) $display("FAIL zero_wait_latency: done at cycle %0d required 5", k);
        else n_pass++;
        n_checks++;
        if ({b_busy, b_pass_idx} !== {1'b1, 8'd0})
            $display("FAIL zero_wait_done_state: busy=%b pass_idx=%0d required 1 0", b_busy, b_pass_idx);
        else n_pass++;
        tick;
        n_checks++;
        if ({b_busy, b_done} !== 2'b00) $display("FAIL zero_wait_idle: busy/done=%b required 00", {b_busy, b_done});
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_rounding;
        int k, npasses, exp;
        npasses = 0;
        for (int p = 0; p < 3; p++) pass_q.push_back(p);
        c_start = 1'b1; tick; c_start = 1'b0;
        k = 1;
        while (!c_done && k < 100) begin
            if (c_conv_clr) begin
                npasses++;
                if (pass_q.size() == 0) exp = -1;
                else exp = pass_q.pop_front();
                n_checks++;
                if (c_pass_idx !== 8'(exp))
                    $display("FAIL rounding_pass_idx: pass_idx=%0d required %0d", c_pass_idx, exp);
                else n_pass++;
            end
            tick;
            k++;
        end
        n_checks++;
        if (npasses !== 3 || pass_q.size() != 0)
            $display("FAIL rounding_passes: passes=%0d required 3", npasses);
        else n_pass++;
        n_checks++;
        if (c_pass_idx !== 8'd2) $display("FAIL rounding_last_idx: pass_idx=%0d required 2", c_pass_idx);
        else n_pass++;
        n_checks++;
        if (k !== 22) $display("FAIL rounding_latency: done at cycle %0d required 22", k);
        else n_pass++;
        pass_q.delete();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        reset    = 1'b0;
        a_start  = 1'b0; a_abort = 1'b0; a_ld_ack = 1'b0; a_finish = 1'b0; a_st_ack = 1'b0;
        b_start  = 1'b0; b_abort = 1'b0; b_ld_ack = 1'b1; b_finish = 1'b1; b_st_ack = 1'b1;
        c_start  = 1'b0; c_abort = 1'b0; c_ld_ack = 1'b1; c_finish = 1'b1; c_st_ack = 1'b1;

        test_reset;
        run_layer_a(2, 2, 1'b0, 1'b0, "nominal");
        run_layer_a(1, 2, 1'b1, 1'b0, "stray");
        run_layer_a(0, 0, 1'b0, 1'b1, "hold_finish");
        test_abort;
        test_zero_wait;
        test_rounding;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
